// File: rtl/pico_bus_pkg.sv
// Shared bus definitions for the memory arbiter: FSM state encoding,
// target-decode codes, the latched-request payload and the LED address default.
package pico_bus_pkg;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'h1000_0000;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TGT_RAM      = 2'd0,
      TGT_LED      = 2'd1,
      TGT_UNMAPPED = 2'd2
   } target_t;

   // Request state kept for the ACCESS/DONE phases; address and write data
   // live in the RAM drive registers, only the LED byte is kept here.
   typedef struct packed {
      logic       port;
      target_t    target;
      logic [3:0] wstrb;
      logic [7:0] led_data;
   } bus_req_t;

   // Classify a byte address: exact LED match, RAM window at the bottom, else unmapped.
   function automatic target_t decode_target(input logic [31:0] addr,
                                             input logic [31:0] led_addr,
                                             input int unsigned ram_aw);
      if (addr == led_addr)
         return TGT_LED;
      else if ((addr >> (ram_aw + 32'd2)) == 32'h0)
         return TGT_RAM;
      else
         return TGT_UNMAPPED;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
//   clk, rst  : clock, async active-high reset
//   req[1:0]  : request vector (bit 0 = CPU, bit 1 = loader)
//   update    : a grant is being taken this cycle; remember who won
//   grant[1:0]: one-hot grant (combinational from req and last-grant flop)
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // 1 = loader won last; reset to loader so the CPU wins the first tie
   logic last;

   // On a tie grant the requester that did not win last time.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (update && (grant != 2'b00))
         last <= grant[1];
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a loader port onto one synchronous single-port RAM
// plus a memory-mapped 8-bit LED register. One transaction per 3 cycles:
// IDLE (grant) -> ACCESS (RAM driven) -> DONE (ready pulse + read data).
//   clk, rst                              : clock, async active-high reset
//   cpu_valid/instr/addr/wdata/wstrb      : CPU request (instr is informational)
//   cpu_ready/cpu_rdata                   : CPU completion pulse / read data
//   ldr_valid/addr/wdata/wstrb            : loader request
//   ldr_ready/ldr_rdata                   : loader completion pulse / read data
//   ram_addr/wdata/byteena/wren, ram_q    : RAM drive and read data
//   led                                   : LED register
module mem_arbiter
   import pico_bus_pkg::*;
#(
   parameter int unsigned RAM_AW   = 15,
   parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_valid,
   input  logic              cpu_instr,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_wstrb,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   input  logic              ldr_valid,
   input  logic [31:0]       ldr_addr,
   input  logic [31:0]       ldr_wdata,
   input  logic [3:0]        ldr_wstrb,
   output logic              ldr_ready,
   output logic [31:0]       ldr_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_byteena,
   output logic              ram_wren,
   input  logic [31:0]       ram_q,
   output logic [7:0]        led
);

   state_t      state;
   bus_req_t    req_q;
   logic [1:0]  gnt;
   logic        take;
   logic        sel_ldr;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   target_t     sel_tgt;
   logic [31:0] rdata_c;

   // The instruction flag carries no behaviour here.
   logic unused_ok;
   assign unused_ok = cpu_instr;

   assign take = (state == ST_IDLE) && (gnt != 2'b00);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({ldr_valid, cpu_valid}),
      .update (take),
      .grant  (gnt)
   );

   // Mux the winning port's request.
   assign sel_ldr   = gnt[1];
   assign sel_addr  = sel_ldr ? ldr_addr  : cpu_addr;
   assign sel_wdata = sel_ldr ? ldr_wdata : cpu_wdata;
   assign sel_wstrb = sel_ldr ? ldr_wstrb : cpu_wstrb;
   assign sel_tgt   = decode_target(sel_addr, LED_ADDR, RAM_AW);

   // Transaction FSM with registered RAM drive, ready pulses and LED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_q       <= '0;
         cpu_ready   <= 1'b0;
         ldr_ready   <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_byteena <= '0;
         ram_wren    <= 1'b0;
         led         <= '0;
      end else begin
         cpu_ready   <= 1'b0;
         ldr_ready   <= 1'b0;
         ram_byteena <= '0;
         ram_wren    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (take) begin
                  req_q.port     <= sel_ldr ? PORT_LDR : PORT_CPU;
                  req_q.target   <= sel_tgt;
                  req_q.wstrb    <= sel_wstrb;
                  req_q.led_data <= sel_wdata[7:0];
                  // RAM is driven during ACCESS, so load it on the grant edge
                  ram_addr       <= sel_addr[RAM_AW+1:2];
                  ram_wdata      <= sel_wdata;
                  ram_byteena    <= sel_wstrb;
                  ram_wren       <= (sel_wstrb != 4'b0000) && (sel_tgt == TGT_RAM);
                  state          <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // Only strobe bit 0 writes the LED byte
               if ((req_q.target == TGT_LED) && req_q.wstrb[0])
                  led <= req_q.led_data;
               cpu_ready <= (req_q.port == PORT_CPU);
               ldr_ready <= (req_q.port == PORT_LDR);
               state     <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read data for the completing transaction; ram_q is valid during DONE.
   always_comb begin
      rdata_c = 32'h0;
      if (req_q.wstrb == 4'b0000) begin
         case (req_q.target)
            TGT_RAM: rdata_c = ram_q;
            TGT_LED: rdata_c = {24'h0, led};
            default: rdata_c = 32'h0;
         endcase
      end
   end

   assign cpu_rdata = cpu_ready ? rdata_c : 32'h0;
   assign ldr_rdata = ldr_ready ? rdata_c : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_valid = 1'b0, cpu_instr = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [3:0]  cpu_wstrb = '0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        ldr_valid = 1'b0;
   logic [31:0] ldr_addr = '0, ldr_wdata = '0;
   logic [3:0]  ldr_wstrb = '0;
   logic        ldr_ready;
   logic [31:0] ldr_rdata;
   logic [14:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_byteena;
   logic        ram_wren;
   logic [31:0] ram_q = '0;
   logic [7:0]  led;

   logic [31:0] mem [0:32767];

   int n_checks = 0;
   int n_pass   = 0;

   logic [14:0] acc_addr;
   logic        acc_wren;
   logic [3:0]  acc_be;
   logic [31:0] rd;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_wstrb(ldr_wstrb), .ldr_ready(ldr_ready), .ldr_rdata(ldr_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteena(ram_byteena),
      .ram_wren(ram_wren), .ram_q(ram_q), .led(led)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read data one clock after the address edge.
   always @(posedge clk) begin
      if (ram_wren)
         for (int b = 0; b < 4; b++)
            if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // One transaction from IDLE; checks ACCESS/DONE timing and returns read data.
   task automatic run_txn(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
      @(negedge clk);
      if (port) begin
         ldr_valid = 1'b1; ldr_addr = addr; ldr_wdata = wdata; ldr_wstrb = wstrb;
      end else begin
         cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
      end
      @(negedge clk);  // ACCESS
      cpu_valid = 1'b0; ldr_valid = 1'b0;
      cpu_addr = 32'hFFFF_FFFC; ldr_addr = 32'hFFFF_FFFC;
      cpu_wdata = 32'h0BAD_0BAD; ldr_wdata = 32'h0BAD_0BAD;
      cpu_wstrb = 4'hF; ldr_wstrb = 4'hF;
      acc_addr = ram_addr; acc_wren = ram_wren; acc_be = ram_byteena;
      check("access_ready", {31'h0, port ? ldr_ready : cpu_ready}, 32'h0);
      check("access_rdata", cpu_rdata | ldr_rdata, 32'h0);
      @(negedge clk);  // DONE
      check("done_ready", {31'h0, port ? ldr_ready : cpu_ready}, 32'h1);
      check("done_other_ready", {31'h0, port ? cpu_ready : ldr_ready}, 32'h0);
      check("done_wren", {31'h0, ram_wren}, 32'h0);
      rdata = port ? ldr_rdata : cpu_rdata;
      @(negedge clk);  // back in IDLE
      check("idle_ready", {30'h0, cpu_ready, ldr_ready}, 32'h0);
      cpu_wstrb = 4'h0; ldr_wstrb = 4'h0;
   endtask

   initial begin
      logic got [6];
      int   nr;
      logic overlap;
      logic seen;

      for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
      mem[0] = 32'h1234_5678;
      mem[2] = 32'hAABB_CCDD;
      mem[4] = 32'hDEAD_BEEF;

      // Reset state
      @(negedge clk); @(negedge clk);
      check("rst_ready", {30'h0, cpu_ready, ldr_ready}, 32'h0);
      check("rst_rdata", cpu_rdata | ldr_rdata, 32'h0);
      check("rst_led", {24'h0, led}, 32'h0);
      check("rst_wren_be", {27'h0, ram_wren, ram_byteena}, 32'h0);
      check("rst_ram_addr", {17'h0, ram_addr}, 32'h0);
      rst = 1'b0;

      // Round robin with both ports valid continuously: CPU first after reset
      @(negedge clk);
      cpu_valid = 1'b1; cpu_addr = 32'h0; cpu_wstrb = 4'h0;
      ldr_valid = 1'b1; ldr_addr = 32'h4; ldr_wstrb = 4'h0;
      nr = 0; overlap = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (cpu_ready && ldr_ready) overlap = 1'b1;
         if (cpu_ready || ldr_ready) begin
            if (nr < 6) got[nr] = ldr_ready;
            nr++;
         end
         if (cpu_ready) check("rr_cpu_rdata", cpu_rdata, 32'h1234_5678);
      end
      cpu_valid = 1'b0; ldr_valid = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("rr_count", nr, 6);
      check("rr_overlap", {31'h0, overlap}, 32'h0);
      for (int k = 0; k < 6; k++)
         check($sformatf("rr_grant_%0d", k), {31'h0, got[k]}, 32'(k % 2));

      // CPU read of RAM word 4
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'b0000, rd);
      check("rd_ram_addr", {17'h0, acc_addr}, 32'd4);
      check("rd_wren", {31'h0, acc_wren}, 32'h0);
      check("rd_data", rd, 32'hDEAD_BEEF);

      // CPU halfword write to word 2, then read back
      run_txn(1'b0, 32'h0000_0008, 32'h1122_3344, 4'b0011, rd);
      check("wr_ram_addr", {17'h0, acc_addr}, 32'd2);
      check("wr_wren", {31'h0, acc_wren}, 32'h1);
      check("wr_be", {28'h0, acc_be}, 32'h3);
      check("wr_rdata", rd, 32'h0);
      run_txn(1'b0, 32'h0000_0008, 32'h0, 4'b0000, rd);
      check("wr_readback", rd, 32'hAABB_3344);

      // LED write via loader, readback, then strobe without bit 0
      run_txn(1'b1, 32'h1000_0000, 32'h0000_00A5, 4'b0001, rd);
      check("led_wr_wren", {31'h0, acc_wren}, 32'h0);
      check("led_value", {24'h0, led}, 32'h0000_00A5);
      run_txn(1'b1, 32'h1000_0000, 32'h0, 4'b0000, rd);
      check("led_readback", rd, 32'h0000_00A5);
      run_txn(1'b0, 32'h1000_0000, 32'h0000_005A, 4'b0010, rd);
      check("led_unchanged", {24'h0, led}, 32'h0000_00A5);

      // Unmapped read and write
      run_txn(1'b0, 32'h8000_0000, 32'h0, 4'b0000, rd);
      check("unm_rdata", rd, 32'h0);
      check("unm_rd_wren", {31'h0, acc_wren}, 32'h0);
      run_txn(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, rd);
      check("unm_wr_wren", {31'h0, acc_wren}, 32'h0);
      run_txn(1'b0, 32'h0000_0000, 32'h0, 4'b0000, rd);
      check("unm_ram_intact", rd, 32'h1234_5678);

      // Reset during ACCESS of a RAM write
      @(negedge clk);
      cpu_valid = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h5566_7788; cpu_wstrb = 4'hF;
      @(negedge clk);
      cpu_valid = 1'b0;
      check("mid_wren_before", {31'h0, ram_wren}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_wren_be", {27'h0, ram_wren, ram_byteena}, 32'h0);
      check("mid_rst_addr", {17'h0, ram_addr}, 32'h0);
      check("mid_rst_led", {24'h0, led}, 32'h0);
      @(negedge clk);
      rst = 1'b0; cpu_wstrb = 4'h0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | cpu_ready | ldr_ready;
      end
      check("mid_no_ready", {31'h0, seen}, 32'h0);
      check("mid_led", {24'h0, led}, 32'h0);
      run_txn(1'b0, 32'h0000_0040, 32'h0, 4'b0000, rd);
      check("mid_write_dropped", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
